// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and defaults for the UART receive path.
//   uart_rx_state_t : receiver state encoding (IDLE, START, DATA, PARITY, STOP)
//   UART_OVERSAMPLE_DEF / UART_DATA_BITS_DEF : default frame geometry
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_rx_state_t;

  localparam int UART_OVERSAMPLE_DEF = 16;
  localparam int UART_DATA_BITS_DEF  = 8;

endpackage

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
// Two-flop synchronizer for an asynchronous single-bit input.
// Parameters:
//   RST_VAL : value both flops take in reset (idle level of the input)
// Ports:
//   clk : system clock
//   rst : synchronous active-high reset
//   d   : asynchronous input
//   q   : synchronized output, two clk cycles behind d
// -----------------------------------------------------------------------------
module uart_rx_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic sync_p0;
  logic sync_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= RST_VAL;
      sync_p1 <= RST_VAL;
    end else begin
      // stage 0: capture the raw line (may go metastable)
      sync_p0 <= d;
      // stage 1: settled copy used by downstream logic
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// UART receiver. Oversamples the line with an rx_tick enable running at
// OVERSAMPLE x baud, validates the start bit at its midpoint, shifts data in
// LSB-first, checks the stop bit (and optionally even parity) and presents
// each byte on a valid/ready handshake.
//
// Build option:
//   UART_RX_PARITY_EN : when defined, one even-parity bit follows the data bits
//                       and parity_err is live; otherwise parity_err is tied 0.
//
// Parameters:
//   DATA_BITS  : data bits per frame (5..8)
//   OVERSAMPLE : rx_tick pulses per bit period (power of two, >= 8)
// Ports:
//   clk        : system clock
//   rst        : synchronous active-high reset
//   rx_tick    : one-cycle oversample enable
//   rx         : asynchronous serial line, idle high
//   rx_data    : last received byte
//   rx_valid   : rx_data holds an unconsumed byte
//   rx_ready   : consumer accepts the byte
//   frame_err  : one-cycle pulse, stop bit sampled low
//   parity_err : one-cycle pulse, parity mismatch
//   overrun    : one-cycle pulse, unconsumed byte overwritten
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int DATA_BITS  = uart_pkg::UART_DATA_BITS_DEF,
  parameter int OVERSAMPLE = uart_pkg::UART_OVERSAMPLE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  import uart_pkg::*;

  localparam int TCNT_W = $clog2(OVERSAMPLE);
  localparam int BCNT_W = $clog2(DATA_BITS);

  localparam logic [TCNT_W-1:0] TCNT_MID  = TCNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(OVERSAMPLE - 1);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(DATA_BITS - 1);

  logic                 rx_s;
  uart_rx_state_t       state;
  logic                 armed;
  logic [TCNT_W-1:0]    tcnt;
  logic [BCNT_W-1:0]    bcnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 bit_end;

`ifdef UART_RX_PARITY_EN
  logic                 par_bad;
  logic                 parity_err_q;
`endif

  uart_rx_sync #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  // The counter wraps to 0 by itself on the tick after TCNT_LAST, so every
  // bit-centred state samples exactly one bit period after the previous one.
  assign bit_end = (tcnt == TCNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      armed     <= 1'b0;
      tcnt      <= '0;
      bcnt      <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad      <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif

      // An accept clears valid; a byte load later in this block overrides it.
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      if (rx_tick) begin
        case (state)
          IDLE: begin
            tcnt <= '0;
            bcnt <= '0;
            // armed blocks a held-low line (break) from looking like a start
            if (rx_s) begin
              armed <= 1'b1;
            end else if (armed) begin
              state <= START;
            end
          end

          START: begin
            tcnt <= tcnt + 1'b1;
            if (tcnt == TCNT_MID) begin
              tcnt  <= '0;
              bcnt  <= '0;
              state <= rx_s ? IDLE : DATA;
            end
          end

          DATA: begin
            tcnt <= tcnt + 1'b1;
            if (bit_end) begin
              shreg <= {rx_s, shreg[DATA_BITS-1:1]};
              bcnt  <= bcnt + 1'b1;
              if (bcnt == BCNT_LAST) begin
                bcnt  <= '0;
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end
            end
          end

`ifdef UART_RX_PARITY_EN
          PARITY: begin
            tcnt <= tcnt + 1'b1;
            if (bit_end) begin
              // even parity: data bits XOR parity bit must be 0
              par_bad <= (^shreg) ^ rx_s;
              state   <= STOP;
            end
          end
`endif

          STOP: begin
            tcnt <= tcnt + 1'b1;
            if (bit_end) begin
              state <= IDLE;
              if (!rx_s) begin
                frame_err <= 1'b1;
                armed     <= 1'b0;
              end
`ifdef UART_RX_PARITY_EN
              else if (par_bad) begin
                parity_err_q <= 1'b1;
              end
`endif
              else begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
                // a same-cycle accept frees the slot, so no overrun then
                overrun  <= rx_valid & ~rx_ready;
              end
            end
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Self-checking bench for uart_rx (8 data bits, 16x oversampling). Frames are
// built as plain lists of line levels and held for a whole bit period each;
// expected results follow from the frame contents alone. Honours
// UART_RX_PARITY_EN so the same bench covers both builds.
// -----------------------------------------------------------------------------
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_tick = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;

  int n_checks = 0;
  int n_pass   = 0;

  int tick_div = 27;
  int tick_cnt = 0;

  // event counters maintained away from the clock edge
  int   n_fe = 0, n_pe = 0, n_ov = 0, n_wide = 0;
  logic fe_d = 1'b0, pe_d = 1'b0, ov_d = 1'b0;

  // snapshots taken inside send_frame at chosen cycles
  logic       snap_a_valid, snap_b_valid, snap_b_ov;
  logic [7:0] snap_a_data, snap_b_data;
  logic       snap_r_valid, snap_r_fe, snap_r_pe, snap_r_ov;
  logic [7:0] snap_r_data;

`ifdef UART_RX_PARITY_EN
  localparam int NPAR = 1;
`else
  localparam int NPAR = 0;
`endif
  // With a tick every clk: 2 sync cycles + 1 detect, 8 ticks to mid-start,
  // then 16 ticks per data/parity/stop bit. Index counts posedges after the
  // negedge that drives the start bit.
  localparam int LOAD_POS = 3 + 8 + 16 * (8 + NPAR + 1);

  uart_rx #(
    .DATA_BITS  (8),
    .OVERSAMPLE (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_tick    (rx_tick),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tick_cnt >= tick_div - 1) begin
      tick_cnt = 0;
      rx_tick  = 1'b1;
    end else begin
      tick_cnt = tick_cnt + 1;
      rx_tick  = 1'b0;
    end
  end

  always @(posedge clk) begin
    #2;
    if (frame_err)  n_fe = n_fe + 1;
    if (parity_err) n_pe = n_pe + 1;
    if (overrun)    n_ov = n_ov + 1;
    if ((frame_err && fe_d) || (parity_err && pe_d) || (overrun && ov_d))
      n_wide = n_wide + 1;
    fe_d = frame_err;
    pe_d = parity_err;
    ov_d = overrun;
  end

  function automatic int bp();
    return 16 * tick_div;
  endfunction

  task automatic idle_cycles(input int n);
    @(negedge clk);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic consume();
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  // Drives one frame; ready_at / rst_at are cycle indices (or -1) at which a
  // one-cycle rx_ready or rst pulse is driven.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input int ready_at, input int rst_at);
    logic lv [0:11];
    int   nb;
    int   b;
    b = bp();
    lv[0] = 1'b0;
    for (int k = 0; k < 8; k++) lv[1 + k] = d[k];
    nb = 9;
`ifdef UART_RX_PARITY_EN
    lv[nb] = par;
    nb = nb + 1;
`else
    if (par) nb = nb + 0;
`endif
    lv[nb] = stop;
    nb = nb + 1;
    for (int i = 0; i < nb * b; i++) begin
      @(negedge clk);
      if (ready_at >= 0 && i == ready_at + 1) begin
        snap_b_valid = rx_valid;
        snap_b_data  = rx_data;
        snap_b_ov    = overrun;
        rx_ready     = 1'b0;
      end
      if (rst_at >= 0 && i == rst_at + 1) begin
        snap_r_valid = rx_valid;
        snap_r_data  = rx_data;
        snap_r_fe    = frame_err;
        snap_r_pe    = parity_err;
        snap_r_ov    = overrun;
        rst          = 1'b0;
      end
      if (i == ready_at) begin
        snap_a_valid = rx_valid;
        snap_a_data  = rx_data;
        rx_ready     = 1'b1;
      end
      if (i == rst_at) rst = 1'b1;
      rx = lv[i / b];
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (rx_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", rx_valid); else n_pass++;
    n_checks++; if (rx_data !== 8'h00) $display("FAIL reset_data: got %h want 00", rx_data); else n_pass++;
    n_checks++; if ({frame_err, parity_err, overrun} !== 3'b000)
      $display("FAIL reset_flags: got %b want 000", {frame_err, parity_err, overrun}); else n_pass++;
    rst = 1'b0;
    idle_cycles(60);
  endtask

  task automatic test_basic();
    int fe0, pe0, ov0;
    tick_div = 27;
    idle_cycles(2 * bp());
    fe0 = n_fe; pe0 = n_pe; ov0 = n_ov;
    send_frame(8'hA5, ^8'hA5, 1'b1, -1, -1);
    n_checks++; if (rx_valid !== 1'b1) $display("FAIL basic_valid: got %b want 1", rx_valid); else n_pass++;
    n_checks++; if (rx_data !== 8'hA5) $display("FAIL basic_data: got %h want a5", rx_data); else n_pass++;
    idle_cycles(200);
    n_checks++; if (rx_valid !== 1'b1 || rx_data !== 8'hA5)
      $display("FAIL basic_hold: got %b/%h want 1/a5", rx_valid, rx_data); else n_pass++;
    n_checks++; if (n_fe - fe0 + n_pe - pe0 + n_ov - ov0 !== 0)
      $display("FAIL basic_noerr: got %0d error pulses want 0", n_fe - fe0 + n_pe - pe0 + n_ov - ov0); else n_pass++;
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    n_checks++; if (rx_valid !== 1'b0) $display("FAIL basic_accept: got %b want 0", rx_valid); else n_pass++;
  endtask

  task automatic test_glitch();
    int fe0, pe0, ov0;
    tick_div = 3;
    idle_cycles(2 * bp());
    fe0 = n_fe; pe0 = n_pe; ov0 = n_ov;
    @(negedge clk);
    rx = 1'b0;
    repeat (4 * tick_div) @(negedge clk);
    rx = 1'b1;
    idle_cycles(3 * bp());
    n_checks++; if (rx_valid !== 1'b0) $display("FAIL glitch_valid: got %b want 0", rx_valid); else n_pass++;
    n_checks++; if (n_fe - fe0 + n_pe - pe0 + n_ov - ov0 !== 0)
      $display("FAIL glitch_flags: got %0d pulses want 0", n_fe - fe0 + n_pe - pe0 + n_ov - ov0); else n_pass++;
    send_frame(8'h5A, ^8'h5A, 1'b1, -1, -1);
    n_checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h5A)
      $display("FAIL glitch_next: got %b/%h want 1/5a", rx_valid, rx_data); else n_pass++;
    consume();
  endtask

  task automatic test_frame_err();
    int fe0;
    tick_div = 2;
    idle_cycles(2 * bp());
    fe0 = n_fe;
    send_frame(8'h3C, ^8'h3C, 1'b0, -1, -1);
    // keep the line low as a break; it must not retrigger reception
    repeat (3 * bp()) @(negedge clk);
    n_checks++; if (n_fe - fe0 !== 1) $display("FAIL ferr_count: got %0d want 1", n_fe - fe0); else n_pass++;
    n_checks++; if (rx_valid !== 1'b0) $display("FAIL ferr_valid: got %b want 0", rx_valid); else n_pass++;
    idle_cycles(bp());
    send_frame(8'h55, ^8'h55, 1'b1, -1, -1);
    n_checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h55)
      $display("FAIL ferr_next: got %b/%h want 1/55", rx_valid, rx_data); else n_pass++;
    n_checks++; if (n_fe - fe0 !== 1) $display("FAIL ferr_after: got %0d want 1", n_fe - fe0); else n_pass++;
    consume();
  endtask

  task automatic test_back_to_back();
    int ov0;
    tick_div = 1;
    idle_cycles(2 * bp());
    ov0 = n_ov;
    send_frame(8'h11, ^8'h11, 1'b1, -1, -1);
    send_frame(8'h22, ^8'h22, 1'b1, -1, -1);
    idle_cycles(4);
    n_checks++; if (n_ov - ov0 !== 1) $display("FAIL b2b_overrun: got %0d want 1", n_ov - ov0); else n_pass++;
    n_checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h22)
      $display("FAIL b2b_data: got %b/%h want 1/22", rx_valid, rx_data); else n_pass++;
    consume();
    idle_cycles(2 * bp());
    ov0 = n_ov;
    send_frame(8'h11, ^8'h11, 1'b1, -1, -1);
    send_frame(8'h22, ^8'h22, 1'b1, LOAD_POS - 1, -1);
    idle_cycles(4);
    n_checks++; if (snap_a_valid !== 1'b1 || snap_a_data !== 8'h11)
      $display("FAIL b2b_preload: got %b/%h want 1/11", snap_a_valid, snap_a_data); else n_pass++;
    n_checks++; if (snap_b_valid !== 1'b1 || snap_b_data !== 8'h22 || snap_b_ov !== 1'b0)
      $display("FAIL b2b_sameload: got %b/%h/%b want 1/22/0", snap_b_valid, snap_b_data, snap_b_ov); else n_pass++;
    n_checks++; if (n_ov - ov0 !== 0) $display("FAIL b2b_no_overrun: got %0d want 0", n_ov - ov0); else n_pass++;
    consume();
  endtask

  task automatic test_reset_mid();
    int fe0;
    tick_div = 2;
    idle_cycles(2 * bp());
    send_frame(8'h96, ^8'h96, 1'b1, -1, -1);
    idle_cycles(bp());
    fe0 = n_fe;
    send_frame(8'hF0, ^8'hF0, 1'b1, -1, 4 * bp() + bp() / 2);
    idle_cycles(2 * bp());
    n_checks++; if (snap_r_valid !== 1'b0 || snap_r_data !== 8'h00)
      $display("FAIL rstmid_out: got %b/%h want 0/00", snap_r_valid, snap_r_data); else n_pass++;
    n_checks++; if ({snap_r_fe, snap_r_pe, snap_r_ov} !== 3'b000)
      $display("FAIL rstmid_flags: got %b want 000", {snap_r_fe, snap_r_pe, snap_r_ov}); else n_pass++;
    n_checks++; if (rx_valid !== 1'b0 || n_fe - fe0 !== 0)
      $display("FAIL rstmid_abandon: got %b/%0d want 0/0", rx_valid, n_fe - fe0); else n_pass++;
    send_frame(8'hF0, ^8'hF0, 1'b1, -1, -1);
    n_checks++; if (rx_valid !== 1'b1 || rx_data !== 8'hF0)
      $display("FAIL rstmid_next: got %b/%h want 1/f0", rx_valid, rx_data); else n_pass++;
    consume();
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int pe0;
    tick_div = 2;
    idle_cycles(2 * bp());
    pe0 = n_pe;
    send_frame(8'h07, 1'b1, 1'b1, -1, -1);
    n_checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h07 || n_pe - pe0 !== 0)
      $display("FAIL par_good: got %b/%h/%0d want 1/07/0", rx_valid, rx_data, n_pe - pe0); else n_pass++;
    consume();
    idle_cycles(bp());
    send_frame(8'h07, 1'b0, 1'b1, -1, -1);
    idle_cycles(4);
    n_checks++; if (rx_valid !== 1'b0 || n_pe - pe0 !== 1)
      $display("FAIL par_bad: got %b/%0d want 0/1", rx_valid, n_pe - pe0); else n_pass++;
  endtask
`endif

  task automatic test_random();
    int         divs [4] = '{1, 2, 3, 5};
    logic [7:0] d;
    logic       stop, par_ok;
    int         fe0, pe0, ov0;
    int         exp_fe, exp_pe;
    logic       exp_valid;
    for (int k = 0; k < 16; k++) begin
      tick_div = divs[$urandom_range(0, 3)];
      d        = 8'($urandom);
      stop     = ($urandom_range(0, 3) != 0);
`ifdef UART_RX_PARITY_EN
      par_ok   = ($urandom_range(0, 3) != 0);
`else
      par_ok   = 1'b1;
`endif
      idle_cycles(bp() * $urandom_range(1, 3) + $urandom_range(0, 6));
      fe0 = n_fe; pe0 = n_pe; ov0 = n_ov;
      send_frame(d, (^d) ^ ~par_ok, stop, -1, -1);
      idle_cycles(2);
      exp_fe    = stop ? 0 : 1;
      exp_pe    = (stop && !par_ok) ? 1 : 0;
      exp_valid = stop && par_ok;
      n_checks++; if (rx_valid !== exp_valid || n_fe - fe0 !== exp_fe || n_pe - pe0 !== exp_pe || n_ov - ov0 !== 0)
        $display("FAIL rand%0d_status: got v%b fe%0d pe%0d ov%0d want v%b fe%0d pe%0d ov0", k,
                 rx_valid, n_fe - fe0, n_pe - pe0, n_ov - ov0, exp_valid, exp_fe, exp_pe); else n_pass++;
      if (exp_valid) begin
        n_checks++; if (rx_data !== d) $display("FAIL rand%0d_data: got %h want %h", k, rx_data, d); else n_pass++;
        consume();
      end
    end
  endtask

  task automatic test_pulse_width();
    n_checks++; if (n_wide !== 0) $display("FAIL pulse_width: got %0d wide pulses want 0", n_wide); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_mid();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_random();
    test_pulse_width();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver for the serial link, the receive-side partner of the baud clock generator. It oversamples the line with a one-cycle `rx_tick` enable at 16x the baud rate, which is the same rate as the generator's receive clock. It detects and validates a start bit and shifts in data LSB-first. It checks the stop bit, and optionally parity, and presents each byte on a valid/ready handshake with overrun and framing flags.

## Interface
Parameters:
- `DATA_BITS`, default 8: data bits per frame. Legal range 5–8.
- `OVERSAMPLE`, default 16: `rx_tick` pulses per bit period. Must be a power of two, at least 8.

Ports:
- `clk` input, 1 bit: system clock. This is the only clock in the block.
- `rst` input, 1 bit: synchronous, active-high reset.
- `rx_tick` input, 1 bit: single-cycle oversample enable at OVERSAMPLE × baud.
- `rx` input, 1 bit: asynchronous serial line, idle high.
- `rx_data` output, DATA_BITS bits: last received byte.
- `rx_valid` output, 1 bit: `rx_data` holds an unconsumed byte.
- `rx_ready` input, 1 bit: consumer accepts the byte.
- `frame_err` output, 1 bit: one-cycle pulse; stop bit sampled low.
- `parity_err` output, 1 bit: one-cycle pulse; parity mismatch. Tied 0 when parity is compiled out.
- `overrun` output, 1 bit: one-cycle pulse; a new byte overwrote an unconsumed byte.

## Operation
- `rx` passes through a 2-flop synchronizer (reset value 1) to produce `rx_s`. All decisions use `rx_s`.
- The state machine advances only on cycles where `rx_tick` = 1. `tcnt` is a log2(OVERSAMPLE)-bit tick counter. `bcnt` counts data bits.
- `IDLE`:
  - Requires `armed` = 1. `armed` is set when `rx_s` = 1 is seen on a tick.
  - `rx_s` = 0 on a tick → go to `START`, with `tcnt` = 0.
- `START`:
  - Increment `tcnt`.
  - At `tcnt` = OVERSAMPLE/2−1 (mid-bit), if `rx_s` = 0 → go to `DATA` with `tcnt` = 0 and `bcnt` = 0.
  - If `rx_s` = 1 → false start; return to `IDLE`. No flags.
- `DATA`:
  - At `tcnt` = OVERSAMPLE−1, sample `rx_s` into the shift register MSB and shift right, so data arrives LSB-first. Then `tcnt` wraps to 0 and `bcnt` increments.
  - After bit DATA_BITS−1 → go to `PARITY` if compiled in, else `STOP`.
- `PARITY`: at `tcnt` = OVERSAMPLE−1, sample the parity bit and compare → go to `STOP`.
- `STOP`: at `tcnt` = OVERSAMPLE−1, sample `rx_s`.
  - `rx_s` = 1, parity OK → load `rx_data` from the shift register and set `rx_valid`.
  - `rx_s` = 1, parity bad → pulse `parity_err`; byte discarded, `rx_data`/`rx_valid` unchanged.
  - `rx_s` = 0 → pulse `frame_err`, discard the byte, clear `armed`. This prevents a break condition from retriggering.
  - In all cases → go to `IDLE`.
- Handshake:
  - `rx_valid` and `rx_ready` both high → `rx_valid` clears next cycle.
  - A byte load while `rx_valid` = 1 and `rx_ready` = 0 → overwrite `rx_data`, keep `rx_valid` = 1, pulse `overrun`.
  - A load in the same cycle as an accept → the new byte is loaded, `rx_valid` stays 1, and there is no `overrun`.
- Reset mid-frame: the frame is abandoned and the block returns to `IDLE` with `armed` = 0.

## Timing
- Reset values:
  - `rx_data` = 0, `rx_valid` = 0.
  - `frame_err` = 0, `parity_err` = 0, `overrun` = 0.
  - State = `IDLE`, `armed` = 0, `tcnt` = 0, `bcnt` = 0.
  - Both synchronizer flops = 1.
- Line to decision latency: 2 `clk` cycles through the synchronizer.
- `rx_valid`, `rx_data` and the error pulses are registered. They change on the `clk` edge after the `rx_tick` cycle on which the stop bit is sampled.
- The stop-bit sample falls at the stop-bit midpoint, about 9.5 bit periods after the start edge. `rx_valid` asserts roughly half a bit before the line's stop bit ends, so back-to-back frames are supported.
- Every error pulse is exactly one `clk` cycle wide.
- `rx_tick` held constantly high is legal. In that case `clk` itself is the oversample clock.

## Configuration
- `UART_RX_PARITY_EN`:
  - Defined: the `PARITY` state is compiled in and expects even parity, i.e. the XOR of the data bits and the parity bit equals 0. `parity_err` is live.
  - Undefined: the `PARITY` state is absent, `DATA` goes directly to `STOP`, and `parity_err` is tied 0.

## Structure
- Package `uart_pkg` holds:
  - The state enum `uart_rx_state_t` (`IDLE`, `START`, `DATA`, `PARITY`, `STOP`).
  - Localparams for default OVERSAMPLE and DATA_BITS.
- Sub-module `uart_rx_sync`: 2-flop synchronizer with a parameterised reset value. It is reused by other async inputs.

## Test plan
- Send 0xA5, 8N1, `rx_tick` every 27 `clk` (115200 baud at 50 MHz), `rx_ready` = 0 → `rx_data` = 0xA5, `rx_valid` = 1 and held. Pulsing `rx_ready` → `rx_valid` = 0 next cycle.
- Line glitched low for 4 ticks, then high → no `rx_valid`, no error pulses, state returns to `IDLE`.
- 0x3C sent with stop bit driven 0 → one-cycle `frame_err`, `rx_valid` stays 0. A following valid 0x55 is not received until the line has returned high.
- Frames 0x11 then 0x22 sent back-to-back with `rx_ready` = 0 → `overrun` pulses once and `rx_data` = 0x22. Repeating with `rx_ready` asserted in the load cycle → no `overrun`.
- `rst` asserted for 1 cycle in the middle of data bit 3 → all outputs at reset values. A next frame of 0xF0 is received correctly.
- With `UART_RX_PARITY_EN`: send 0x07 with parity bit 1 → `rx_data` = 0x07. Send 0x07 with parity bit 0 → `parity_err` pulse and no `rx_valid`.
